mmio_gpio_blink: RTL and testbench
==================================

MMIO_GPIO_BLINK -- requirements
Module: mmio_gpio_blink

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of output channels (legal 1..16).
REQ-002 SHALL have parameter DIV_W, default 24, prescaler width in bits (legal 1..32).
REQ-003 SHALL have parameter DIV_RST, default 2**20-1, DIV register reset value (must fit DIV_W).
REQ-004 SHALL have port: clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port: resetn  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port: bus_valid  in  1  access request, held until bus_ready.
REQ-007 SHALL have port: bus_we  in  1  1=write, 0=read.
REQ-008 SHALL have port: bus_addr  in  4  byte offset; bits[1:0] ignored.
REQ-009 SHALL have port: bus_wdata  in  32  write data.
REQ-010 SHALL have port: bus_rdata  out  32  read data, valid while bus_ready=1.
REQ-011 SHALL have port: bus_ready  out  1  one-cycle completion pulse.
REQ-012 SHALL have port: gpio_out  out  NUM_CH  registered channel outputs (LEDs/pins).
REQ-013 SHALL have port: tick  out  1  one-cycle prescaler tick pulse.

Function
REQ-014 SHALL map registers: 0x0 CTRL (RW), 0x4 DIV (RW, DIV_W LSBs), 0x8 OUT (RO, gpio_out zero-extended), 0xC TICKCNT (RO, 32-bit).
REQ-015 SHALL hold channel i mode in CTRL[2i+1:2i]: 00 off, 01 on, 10 blink, 11 pulse; bits above 2*NUM_CH read 0, writes ignored.
REQ-016 SHALL accept an access on any cycle with bus_valid=1 and bus_ready=0; bus_ready=1 exactly the following cycle; bus_valid ignored while bus_ready=1 (no back-to-back acceptance).
REQ-017 SHALL take effect of an accepted write at the same edge that raises bus_ready.
REQ-018 SHALL capture read data at acceptance edge; bus_rdata=0 whenever bus_ready=0.
REQ-019 SHALL return 0 for unmapped offsets and ignore writes to them and to OUT/TICKCNT.
REQ-020 SHALL run a down-counter of width DIV_W: at 0 it asserts tick for one cycle and reloads DIV; otherwise decrements.
REQ-021 SHALL, with DIV=0, assert tick every cycle; period is DIV+1 cycles.
REQ-022 SHALL, on DIV write, load the counter with the new value at that edge (no tick that cycle; old count discarded).
REQ-023 SHALL increment TICKCNT on every tick, wrapping 0xFFFFFFFF->0.
REQ-024 SHALL drive channel in mode off 0, on 1; blink toggles gpio_out[i] on each tick.
REQ-025 SHALL, in pulse mode, drive 1 until the next tick, then set gpio_out[i]=0 and clear the channel's CTRL mode to 00 at that tick edge.
REQ-026 SHALL, on a CTRL write changing a channel's mode, set gpio_out[i] to 0 for off/blink and 1 for on/pulse at the write edge.
REQ-027 SHALL give a CTRL write priority over a tick in the same cycle (written mode and REQ-026 value win; no toggle/auto-clear that cycle).
REQ-028 SHALL leave channels whose mode field is rewritten unchanged unaffected (no phase reset).

Reset
REQ-029 SHALL, when resetn=0 at a rising edge: CTRL=0, DIV=DIV_RST, counter=DIV_RST, TICKCNT=0, gpio_out=0, tick=0, bus_ready=0, bus_rdata=0.
REQ-030 SHALL abort any in-flight access on reset; no bus_ready pulse for it after resetn rises.
REQ-031 SHALL begin counting on the first edge with resetn=1; first tick DIV_RST+1 cycles later.

Verification
REQ-032 Reset then read 0x4 -> bus_ready 1 cycle after valid, bus_rdata=DIV_RST; read 0x0/0x8/0xC -> 0.
REQ-033 Write DIV=3, CTRL=0x2 (ch0 blink) -> tick every 4 cycles, gpio_out[0] toggles each tick, TICKCNT counts ticks.
REQ-034 DIV=0, CTRL=0xC0 (ch3 pulse) -> gpio_out[3]=1 at write edge, 0 next tick; CTRL reads 0 afterwards.
REQ-035 CTRL write coinciding with tick (DIV=1, ch0 blink) -> gpio_out[0]=0 after edge, no toggle; next tick toggles to 1.
REQ-036 Assert resetn=0 one cycle after bus_valid accepted -> no bus_ready, all registers at reset values; bus_valid held across reset accepted normally after.
REQ-037 Write 0xFFFFFFFF to CTRL with NUM_CH=4 -> CTRL reads 0x000000FF; write to 0x8 and 0xC -> no change.

Source files
------------

// File: rtl/mmio_gpio_blink.sv
// Memory-mapped GPIO block: per-channel off/on/blink/pulse modes driven
// by a programmable prescaler tick, with a tiny valid/ready register bus.
module mmio_gpio_blink #(
    parameter int          NUM_CH  = 4,
    parameter int          DIV_W   = 24,
    parameter int unsigned DIV_RST = 2**20 - 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              bus_valid,
    input  logic              bus_we,
    input  logic [3:0]        bus_addr,
    input  logic [31:0]       bus_wdata,
    output logic [31:0]       bus_rdata,
    output logic              bus_ready,
    output logic [NUM_CH-1:0] gpio_out,
    output logic              tick
);

    localparam int CW = 2 * NUM_CH;
    localparam logic [DIV_W-1:0] DIV_RST_V = DIV_W'(DIV_RST);

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_PULSE = 2'b11;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_DIV  = 2'd1;
    localparam logic [1:0] REG_OUT  = 2'd2;
    localparam logic [1:0] REG_TCNT = 2'd3;

    logic [CW-1:0]     ctrl_q, ctrl_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       tcnt_q, tcnt_d;
    logic [NUM_CH-1:0] gpio_q, gpio_d;
    logic              tick_q, tick_d;
    logic              ready_q, ready_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              accept;
    logic              ctrl_wr;
    logic              div_wr;
    logic              tick_ev;
    logic [31:0]       rd_mux;
    logic              unused_bits;

    assign unused_bits = &{1'b0, bus_addr[1:0], bus_wdata};

    // A new access is only taken when no completion is being presented.
    always_comb begin
        accept  = bus_valid && !ready_q;
        ctrl_wr = accept && bus_we && (bus_addr[3:2] == REG_CTRL);
        div_wr  = accept && bus_we && (bus_addr[3:2] == REG_DIV);
    end

    always_comb begin
        rd_mux = '0;
        unique case (bus_addr[3:2])
            REG_CTRL: rd_mux = 32'(ctrl_q);
            REG_DIV:  rd_mux = 32'(div_q);
            REG_OUT:  rd_mux = 32'(gpio_q);
            REG_TCNT: rd_mux = tcnt_q;
            default:  rd_mux = '0;
        endcase
    end

    always_comb begin
        ready_d = accept;
        rdata_d = (accept && !bus_we) ? rd_mux : '0;
    end

    // A DIV write reloads the counter and swallows any tick due that cycle.
    always_comb begin
        tick_ev = !div_wr && (cnt_q == '0);
        tick_d  = tick_ev;
        div_d   = div_wr ? bus_wdata[DIV_W-1:0] : div_q;
        tcnt_d  = tcnt_q + 32'(tick_ev);
        if (div_wr) begin
            cnt_d = bus_wdata[DIV_W-1:0];
        end else if (tick_ev) begin
            cnt_d = div_q;
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    // Channels whose mode changes take the write value; others run normally.
    always_comb begin
        logic [1:0] cur_m;
        logic [1:0] new_m;
        cur_m  = MODE_OFF;
        new_m  = MODE_OFF;
        ctrl_d = ctrl_q;
        gpio_d = gpio_q;
        for (int i = 0; i < NUM_CH; i++) begin
            cur_m = ctrl_q[2*i +: 2];
            new_m = ctrl_wr ? bus_wdata[2*i +: 2] : cur_m;
            if (new_m != cur_m) begin
                ctrl_d[2*i +: 2] = new_m;
                gpio_d[i]        = new_m[0];
            end else begin
                unique case (cur_m)
                    MODE_OFF: gpio_d[i] = 1'b0;
                    MODE_ON:  gpio_d[i] = 1'b1;
                    MODE_BLINK: begin
                        if (tick_ev) begin
                            gpio_d[i] = !gpio_q[i];
                        end
                    end
                    MODE_PULSE: begin
                        if (tick_ev) begin
                            gpio_d[i]        = 1'b0;
                            ctrl_d[2*i +: 2] = MODE_OFF;
                        end else begin
                            gpio_d[i] = 1'b1;
                        end
                    end
                    default: gpio_d[i] = gpio_q[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ctrl_q  <= '0;
            div_q   <= DIV_RST_V;
            cnt_q   <= DIV_RST_V;
            tcnt_q  <= '0;
            gpio_q  <= '0;
            tick_q  <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            gpio_q  <= gpio_d;
            tick_q  <= tick_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus_rdata = rdata_q;
    assign bus_ready = ready_q;
    assign gpio_out  = gpio_q;
    assign tick      = tick_q;

endmodule

// File: tb/tb_mmio_gpio_blink.sv
// Scoreboard bench for mmio_gpio_blink: random bus traffic against a
// cycle-level behavioural model of the register map and channel modes.
module tb_mmio_gpio_blink;

    localparam int          NUM_CH  = 4;
    localparam int          DIV_W   = 8;
    localparam int unsigned DIV_RST = 9;

    logic              clk = 1'b0;
    logic              resetn;
    logic              bus_valid;
    logic              bus_we;
    logic [3:0]        bus_addr;
    logic [31:0]       bus_wdata;
    logic [31:0]       bus_rdata;
    logic              bus_ready;
    logic [NUM_CH-1:0] gpio_out;
    logic              tick;

    mmio_gpio_blink #(
        .NUM_CH (NUM_CH),
        .DIV_W  (DIV_W),
        .DIV_RST(DIV_RST)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus_valid(bus_valid),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ready(bus_ready),
        .gpio_out (gpio_out),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          we;
        logic [3:0]  addr;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];

    // Behavioural model state
    int unsigned m_mode[NUM_CH];
    bit          m_gpio[NUM_CH];
    int unsigned m_div;
    int unsigned m_left;
    bit [31:0]   m_tcnt;
    bit          m_tick;
    bit          m_ready;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [3:0] a);
        logic [31:0] v;
        v = 0;
        case (a[3:2])
            2'd0: for (int i = 0; i < NUM_CH; i++) v += m_mode[i] << (2 * i);
            2'd1: v = m_div;
            2'd2: for (int i = 0; i < NUM_CH; i++) v += 32'(m_gpio[i]) << i;
            default: v = m_tcnt;
        endcase
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_mode[i] = 0;
            m_gpio[i] = 0;
        end
        m_div   = DIV_RST;
        m_left  = DIV_RST;
        m_tcnt  = 0;
        m_tick  = 0;
        m_ready = 0;
        sb.delete();
    endtask

    initial m_reset();

    always @(posedge clk) begin
        bit          acc;
        bit          dw;
        bit          cw;
        bit          tk;
        int unsigned nm;
        exp_t        e;
        if (!resetn) begin
            m_reset();
        end else begin
            acc = bus_valid && !m_ready;
            dw  = acc && bus_we && (bus_addr[3:2] == 2'd1);
            cw  = acc && bus_we && (bus_addr[3:2] == 2'd0);
            if (acc) begin
                e.we    = bus_we;
                e.addr  = bus_addr;
                e.rdata = m_read(bus_addr);
                sb.push_back(e);
            end
            tk = !dw && (m_left == 0);
            if (dw) begin
                m_div  = bus_wdata % (1 << DIV_W);
                m_left = m_div;
            end else if (tk) begin
                m_left = m_div;
            end else begin
                m_left = m_left - 1;
            end
            if (tk) m_tcnt = m_tcnt + 1;
            for (int i = 0; i < NUM_CH; i++) begin
                nm = cw ? (bus_wdata >> (2 * i)) % 4 : m_mode[i];
                if (nm != m_mode[i]) begin
                    m_mode[i] = nm;
                    m_gpio[i] = (nm == 1) || (nm == 3);
                end else if (tk && m_mode[i] == 2) begin
                    m_gpio[i] = !m_gpio[i];
                end else if (tk && m_mode[i] == 3) begin
                    m_gpio[i] = 0;
                    m_mode[i] = 0;
                end
            end
            m_ready = acc;
            m_tick  = tk;
        end
    end

    always @(negedge clk) begin
        logic [NUM_CH-1:0] eg;
        exp_t              e;
        for (int i = 0; i < NUM_CH; i++) eg[i] = m_gpio[i];
        chk("tick", 32'(tick), 32'(m_tick));
        chk("gpio_out", 32'(gpio_out), 32'(eg));
        chk("bus_ready", 32'(bus_ready), 32'(m_ready));
        if (bus_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", 32'(bus_ready), 32'd0);
            end else begin
                e = sb.pop_front();
                if (!e.we) chk($sformatf("rdata@%0h", e.addr), bus_rdata, e.rdata);
            end
        end else begin
            chk("rdata_idle", bus_rdata, 32'd0);
        end
    end

    task automatic bus(input bit we, input logic [3:0] a, input logic [31:0] d);
        int n;
        bus_valid = 1'b1;
        bus_we    = we;
        bus_addr  = a;
        bus_wdata = d;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus_ready && n < 8);
        if (!bus_ready) chk("bus_timeout", 32'(bus_ready), 32'd1);
        bus_valid = 1'b0;
        bus_we    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!bus_ready && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 32'(bus_ready), 32'd1);
    endtask

    initial begin
        resetn    = 1'b0;
        bus_valid = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        idle(3);
        resetn = 1'b1;

        bus(0, 4'h4, 0);
        bus(0, 4'h0, 0);
        bus(0, 4'h8, 0);
        bus(0, 4'hC, 0);

        bus(1, 4'h4, 3);
        bus(1, 4'h0, 32'h2);
        idle(20);
        bus(0, 4'hC, 0);
        bus(0, 4'h8, 0);

        bus(1, 4'h4, 0);
        bus(1, 4'h0, 32'hC0);
        idle(3);
        bus(0, 4'h0, 0);

        bus(1, 4'h4, 1);
        for (int g = 0; g < 4; g++) begin
            idle(g);
            bus(1, 4'h0, 0);
            bus(1, 4'h0, 32'h2);
            idle(3);
        end

        bus(1, 4'h0, 32'hFFFF_FFFF);
        bus(0, 4'h0, 0);
        bus(1, 4'h8, 32'h5);
        bus(1, 4'hC, 32'h7);
        bus(0, 4'h8, 0);
        bus(0, 4'hC, 0);

        bus_valid = 1'b1;
        bus_we    = 1'b0;
        bus_addr  = 4'h4;
        resetn    = 1'b0;
        idle(2);
        resetn = 1'b1;
        wait_ready("held_valid_after_reset");
        bus_valid = 1'b0;
        bus(1, 4'h4, 2);

        bus_valid = 1'b1;
        bus_we    = 1'b0;
        bus_addr  = 4'h0;
        idle(1);
        resetn = 1'b0;
        idle(2);
        resetn = 1'b1;
        wait_ready("reaccept_after_abort");
        bus_valid = 1'b0;

        for (int k = 0; k < 400; k++) begin
            logic [3:0]  a;
            logic [31:0] d;
            a = {2'($urandom_range(0, 3)), 2'($urandom)};
            d = (a[3:2] == 2'd1) ? 32'($urandom_range(0, 5)) : $urandom;
            bus(1'($urandom), a, d);
            idle($urandom_range(0, 3));
            if ($urandom_range(0, 60) == 0) begin
                resetn = 1'b0;
                idle(2);
                resetn = 1'b1;
            end
        end

        idle(5);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
